// File: rtl/dram_axi_responder.sv
// dram_axi_responder: single-outstanding AR/R + AW/W/B responder backed by a
// DEPTH x 64-bit register array, with fixed read and write response latency.
module dram_axi_responder #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          DEPTH     = 256,
    parameter int          READ_LAT  = 3,
    parameter int          WRITE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY,
    input  logic        ld_en,
    input  logic [7:0]  ld_idx,
    input  logic [63:0] ld_data
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_LAT - 1);
    localparam logic [17:0]      SPAN   = 18'(8 * DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_R_LAT  = 3'd1;
    localparam logic [2:0] S_R_SEND = 3'd2;
    localparam logic [2:0] S_W_WAIT = 3'd3;
    localparam logic [2:0] S_W_LAT  = 3'd4;
    localparam logic [2:0] S_B_SEND = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_addr_ok;
    logic [IDX_W-1:0] r_idx;
    logic [63:0]      r_wdata;
    logic [63:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic [1:0]       r_bresp;
    logic [63:0]      r_mem [DEPTH];

    logic [17:0]      w_ar_off;
    logic [17:0]      w_aw_off;
    logic             w_ar_ok;
    logic             w_aw_ok;
    logic             w_bus_we;

    // A borrow out of the 18-bit subtraction marks an address below BASE_ADDR.
    assign w_ar_off = {1'b0, AR_ADDR} - {1'b0, BASE_ADDR};
    assign w_aw_off = {1'b0, AW_ADDR} - {1'b0, BASE_ADDR};
    assign w_ar_ok  = !w_ar_off[17] && (w_ar_off < SPAN) && (AR_ADDR[2:0] == 3'b000);
    assign w_aw_ok  = !w_aw_off[17] && (w_aw_off < SPAN) && (AW_ADDR[2:0] == 3'b000);

    assign AR_READY = !rst && (r_state == S_IDLE);
    // AW is withheld while AR is presented, so a collision is never a double handshake.
    assign AW_READY = !rst && (r_state == S_IDLE) && !AR_VALID;
    assign W_READY  = !rst && (r_state == S_W_WAIT);
    assign R_VALID  = !rst && (r_state == S_R_SEND);
    assign B_VALID  = !rst && (r_state == S_B_SEND);
    assign R_DATA   = r_rdata;
    assign R_RESP   = r_rresp;
    assign B_RESP   = r_bresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr_ok <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (AR_VALID) begin
                        r_state   <= S_R_LAT;
                        r_cnt     <= '0;
                        r_addr_ok <= w_ar_ok;
                        r_idx     <= w_ar_off[IDX_W+2:3];
                    end else if (AW_VALID) begin
                        r_state   <= S_W_WAIT;
                        r_addr_ok <= w_aw_ok;
                        r_idx     <= w_aw_off[IDX_W+2:3];
                    end
                end
                S_R_LAT: begin
                    if (r_cnt == R_LAST) begin
                        r_state <= S_R_SEND;
                        r_rdata <= r_addr_ok ? r_mem[r_idx] : 64'd0;
                        r_rresp <= r_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_R_SEND: begin
                    if (R_READY) r_state <= S_IDLE;
                end
                S_W_WAIT: begin
                    if (W_VALID) begin
                        r_state <= S_W_LAT;
                        r_cnt   <= '0;
                        r_wdata <= W_DATA;
                    end
                end
                S_W_LAT: begin
                    if (r_cnt == W_LAST) begin
                        r_state <= S_B_SEND;
                        r_bresp <= r_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_B_SEND: begin
                    if (B_READY) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The array commits on the same edge the FSM enters B_SEND; reset suppresses it.
    assign w_bus_we = !rst && (r_state == S_W_LAT) && (r_cnt == W_LAST) && r_addr_ok;

    // NOTE: the array deliberately has no reset so preloaded contents survive a bus
    // reset; the later bus write statement overrides a same-index backdoor load.
    always_ff @(posedge clk) begin
        if (ld_en)    r_mem[ld_idx[IDX_W-1:0]] <= ld_data;
        if (w_bus_we) r_mem[r_idx]             <= r_wdata;
    end

endmodule

// File: tb/tb_dram_axi_responder.sv
// Bench for dram_axi_responder: transaction-level memory model with a per-cycle
// compare process, plus directed reads/writes with literal expectations.
module tb_dram_axi_responder;
    localparam int BASE  = 'h10000;
    localparam int DEPTH = 256;
    localparam int RLAT  = 3;
    localparam int WLAT  = 3;

    logic        clk;
    logic        rst;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [16:0] AR_ADDR;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic [16:0] AW_ADDR;
    logic [63:0] W_DATA;
    logic [1:0]  B_RESP;
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [63:0] ld_data;

    dram_axi_responder dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mm [DEPTH];
    int          cyc = 0;
    bit          rd_pend = 0, rd_ok = 0;
    int          rd_idx = 0, rd_due = 0;
    logic [63:0] rd_exp_data = '0;
    logic [1:0]  rd_exp_resp = '0;
    bit          aw_taken = 0, w_taken = 0, wr_ok = 0;
    int          wr_idx = 0, wr_due = 0;
    logic [63:0] wr_data = '0;
    logic [1:0]  wr_resp = '0;
    int          last_r_hs = 0, last_aw_hs = 0;

    function automatic void dec(input logic [16:0] a, output bit ok, output int idx);
        int ai;
        ai  = int'(a);
        ok  = (ai >= BASE) && (ai < BASE + 8 * DEPTH) && (ai % 8 == 0);
        idx = ok ? (ai - BASE) / 8 : 0;
    endfunction

    // Model update on every rising edge, using the values seen just before the edge.
    initial begin
        bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
        forever begin
            @(posedge clk);
            cyc++;
            ar_hs = AR_VALID && AR_READY;
            aw_hs = AW_VALID && AW_READY;
            w_hs  = W_VALID && W_READY;
            r_hs  = R_VALID && R_READY;
            b_hs  = B_VALID && B_READY;
            if (rst) begin
                rd_pend  = 0;
                aw_taken = 0;
                w_taken  = 0;
                if (ld_en) mm[int'(ld_idx)] = ld_data;
            end else begin
                if (rd_pend && cyc == rd_due) begin
                    rd_exp_data = rd_ok ? mm[rd_idx] : 64'd0;
                    rd_exp_resp = rd_ok ? 2'b00 : 2'b10;
                end
                if (ld_en) mm[int'(ld_idx)] = ld_data;
                if (w_taken && cyc == wr_due && wr_ok) mm[wr_idx] = wr_data;
                if (r_hs) begin rd_pend = 0; last_r_hs = cyc; end
                if (b_hs) begin aw_taken = 0; w_taken = 0; end
                if (ar_hs) begin
                    dec(AR_ADDR, rd_ok, rd_idx);
                    rd_pend = 1;
                    rd_due  = cyc + RLAT;
                end else if (aw_hs) begin
                    dec(AW_ADDR, wr_ok, wr_idx);
                    wr_resp    = wr_ok ? 2'b00 : 2'b10;
                    aw_taken   = 1;
                    last_aw_hs = cyc;
                end
                if (w_hs) begin
                    wr_data = W_DATA;
                    w_taken = 1;
                    wr_due  = cyc + WLAT;
                end
            end
        end
    end

    // Compare process: outputs checked against the model 1 time unit after each edge.
    initial begin
        bit busy, exp_rv, exp_bv;
        forever begin
            @(posedge clk);
            #1;
            busy   = rd_pend || aw_taken;
            exp_rv = rd_pend && (cyc >= rd_due);
            exp_bv = w_taken && (cyc >= wr_due);
            check("ar_ready", 64'(AR_READY), 64'(!rst && !busy));
            if (rst || busy)    check("aw_ready_busy", 64'(AW_READY), 64'd0);
            else if (!AR_VALID) check("aw_ready_idle", 64'(AW_READY), 64'd1);
            check("w_ready", 64'(W_READY), 64'(!rst && aw_taken && !w_taken));
            check("r_valid", 64'(R_VALID), 64'(exp_rv));
            check("b_valid", 64'(B_VALID), 64'(exp_bv));
            if (exp_rv) begin
                check("r_data", R_DATA, rd_exp_data);
                check("r_resp", 64'(R_RESP), 64'(rd_exp_resp));
            end
            if (exp_bv) check("b_resp", 64'(B_RESP), 64'(wr_resp));
        end
    end

    // ---------------- drivers ----------------
    task automatic preload(input logic [7:0] idx, input logic [63:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(negedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_read(input logic [16:0] a, input int hold,
                           output logic [63:0] d, output logic [1:0] resp, output int lat);
        int n;
        AR_ADDR = a; AR_VALID = 1'b1; R_READY = (hold == 0);
        d = '0; resp = '0; lat = 0;
        #1; n = 0;
        while (!AR_READY && n < 50) begin @(negedge clk); #1; n++; end
        check("ar_accept_wait", 64'(AR_READY), 64'd1);
        @(negedge clk);
        AR_VALID = 1'b0;
        #1;
        while (!R_VALID && lat < 50) begin @(negedge clk); #1; lat++; end
        check("r_valid_wait", 64'(R_VALID), 64'd1);
        repeat (hold) @(negedge clk);
        R_READY = 1'b1;
        d = R_DATA; resp = R_RESP;
        @(negedge clk); #1;
        check("r_valid_drop", 64'(R_VALID), 64'd0);
        R_READY = 1'b0;
    endtask

    task automatic aw_phase(input logic [16:0] a);
        int n;
        AW_ADDR = a; AW_VALID = 1'b1;
        #1; n = 0;
        while (!AW_READY && n < 50) begin @(negedge clk); #1; n++; end
        check("aw_accept_wait", 64'(AW_READY), 64'd1);
        @(negedge clk);
        AW_VALID = 1'b0;
    endtask

    task automatic w_phase(input logic [63:0] d, output logic [1:0] resp, output int lat);
        int n;
        W_DATA = d; W_VALID = 1'b1; B_READY = 1'b1;
        resp = '0; lat = 0;
        #1; n = 0;
        while (!W_READY && n < 50) begin @(negedge clk); #1; n++; end
        check("w_accept_wait", 64'(W_READY), 64'd1);
        @(negedge clk);
        W_VALID = 1'b0;
        #1;
        while (!B_VALID && lat < 50) begin @(negedge clk); #1; lat++; end
        check("b_valid_wait", 64'(B_VALID), 64'd1);
        resp = B_RESP;
        @(negedge clk); #1;
        check("b_valid_drop", 64'(B_VALID), 64'd0);
        B_READY = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] d;
        logic [1:0]  resp;
        int          lat;

        rst = 1'b1;
        AR_VALID = 0; AR_ADDR = '0; R_READY = 0;
        AW_VALID = 0; AW_ADDR = '0; W_VALID = 0; W_DATA = '0; B_READY = 0;
        ld_en = 0; ld_idx = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_r_valid", 64'(R_VALID), 64'd0);
        check("rst_b_valid", 64'(B_VALID), 64'd0);
        check("rst_ar_ready", 64'(AR_READY), 64'd0);
        check("rst_r_data", R_DATA, 64'd0);
        check("rst_r_resp", 64'(R_RESP), 64'd0);
        check("rst_b_resp", 64'(B_RESP), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        preload(8'd5,   64'hDEAD_BEEF_0123_4567);
        preload(8'd0,   64'h1111_2222_3333_4444);
        preload(8'd3,   64'h0BAD_F00D_CAFE_0003);
        preload(8'd255, 64'hFFFF_0000_FFFF_00FF);

        // Basic read of a preloaded entry.
        do_read(17'h10028, 0, d, resp, lat);
        check("rd5_data", d, 64'hDEAD_BEEF_0123_4567);
        check("rd5_resp", 64'(resp), 64'd0);
        check("rd5_latency", 64'(lat), 64'd3);

        // Write then read back.
        aw_phase(17'h10010);
        w_phase(64'hA5A5_A5A5_A5A5_A5A5, resp, lat);
        check("wr2_resp", 64'(resp), 64'd0);
        check("wr2_latency", 64'(lat), 64'd3);
        do_read(17'h10010, 0, d, resp, lat);
        check("raw2_data", d, 64'hA5A5_A5A5_A5A5_A5A5);

        // Address decode boundaries.
        do_read(17'h10004, 0, d, resp, lat);
        check("misalign_data", d, 64'd0);
        check("misalign_resp", 64'(resp), 64'd2);
        do_read(17'h10800, 0, d, resp, lat);
        check("oor_data", d, 64'd0);
        check("oor_resp", 64'(resp), 64'd2);
        do_read(17'h107F8, 0, d, resp, lat);
        check("last_entry_data", d, 64'hFFFF_0000_FFFF_00FF);
        check("last_entry_resp", 64'(resp), 64'd0);
        aw_phase(17'h0FFF8);
        w_phase(64'hFFFF_FFFF_FFFF_FFFF, resp, lat);
        check("below_base_bresp", 64'(resp), 64'd2);
        do_read(17'h10000, 0, d, resp, lat);
        check("entry0_unchanged", d, 64'h1111_2222_3333_4444);

        // AR and AW in the same cycle: read first, AW on the next IDLE.
        AR_ADDR = 17'h10028; AR_VALID = 1'b1; R_READY = 1'b1;
        AW_ADDR = 17'h10020; AW_VALID = 1'b1;
        @(negedge clk);
        AR_VALID = 1'b0;
        aw_phase(17'h10020);
        R_READY = 1'b0;
        check("aw_after_read", 64'(last_aw_hs), 64'(last_r_hs + 1));
        w_phase(64'h0000_0000_0000_0077, resp, lat);
        check("coll_bresp", 64'(resp), 64'd0);
        do_read(17'h10020, 0, d, resp, lat);
        check("coll_raw_data", d, 64'h0000_0000_0000_0077);

        // R_READY withheld for 10 cycles.
        do_read(17'h10028, 10, d, resp, lat);
        check("hold_data", d, 64'hDEAD_BEEF_0123_4567);
        check("hold_resp", 64'(resp), 64'd0);

        // Reset in W_LAT aborts the write.
        aw_phase(17'h10018);
        W_DATA = 64'h1; W_VALID = 1'b1;
        #1;
        check("abort_w_ready", 64'(W_READY), 64'd1);
        @(negedge clk);
        W_VALID = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_r_valid", 64'(R_VALID), 64'd0);
        check("abort_b_valid", 64'(B_VALID), 64'd0);
        check("abort_w_ready_low", 64'(W_READY), 64'd0);
        check("abort_aw_ready", 64'(AW_READY), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        do_read(17'h10018, 0, d, resp, lat);
        check("abort_entry_kept", d, 64'h0BAD_F00D_CAFE_0003);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
